// File: rtl/irq_latch_pkg.sv
// irq_latch_pkg: register map, FSM encoding and helpers shared by the
// interrupt latch and its input synchronizer.
package irq_latch_pkg;

    localparam int NIRQ_MAX = 32;

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_ACTIVE  = 2'd2;
    localparam logic [1:0] ADDR_RSVD    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // Index of the lowest set bit; 0 when v is zero.
    function automatic logic [4:0] lowest_idx(input logic [NIRQ_MAX-1:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = NIRQ_MAX - 1; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_latch_sync.sv
// irq_latch_sync: SYNC_STAGES-deep synchronizer per line followed by a
// registered rising-edge detector.
//   clk, reset : clock, async active-high reset
//   irqs       : raw asynchronous level lines
//   evt        : one-cycle pulse per rising edge (registered)
module irq_latch_sync #(
    parameter int NIRQ        = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irqs,
    output logic [NIRQ-1:0] evt
);

    logic [SYNC_STAGES-1:0][NIRQ-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0]           vld_q, vld_d;
    logic [NIRQ-1:0]                  prev_q, prev_d;
    logic [NIRQ-1:0]                  armed_q, armed_d;
    logic [NIRQ-1:0]                  evt_q, evt_d;
    logic [NIRQ-1:0]                  lvl;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], irqs};
        // vld tracks when the last sync stage holds a real sample rather
        // than its reset zero.
        vld_d   = {vld_q[SYNC_STAGES-2:0], 1'b1};
        lvl     = sync_q[SYNC_STAGES-1];
        prev_d  = lvl;
        // A line is only armed once a genuine low has been observed, so a
        // line already high when reset releases never produces an event.
        armed_d = armed_q | (~lvl & {NIRQ{vld_q[SYNC_STAGES-1]}});
        evt_d   = lvl & ~prev_q & armed_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            vld_q   <= '0;
            prev_q  <= '0;
            armed_q <= '0;
            evt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            vld_q   <= vld_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            evt_q   <= evt_d;
        end
    end

    assign evt = evt_q;

endmodule

// File: rtl/irq_latch.sv
// irq_latch: latches rising edges on up to 32 async interrupt lines into
// PENDING, filters by MASK and presents the lowest pending index to the core
// with a req/ack handshake. Registers: 0 PENDING (W1C), 1 MASK, 2 ACTIVE (RO).
//   clk, reset      : clock, async active-high reset
//   irqs            : async level interrupt lines
//   strobe/rw/addr  : bus access (rw=1 write), d_in write data
//   d_out           : registered read data
//   irq_req/irq_num : request and its line index; irq_ack accepts it
module irq_latch
    import irq_latch_pkg::*;
#(
    parameter int NIRQ        = 32,  // 1..NIRQ_MAX
    parameter int SYNC_STAGES = 2    // >= 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irqs,
    input  logic            strobe,
    input  logic            rw,
    input  logic [1:0]      addr,
    input  logic [31:0]     d_in,
    output logic [31:0]     d_out,
    output logic            irq_req,
    output logic [4:0]      irq_num,
    input  logic            irq_ack
);

    logic [NIRQ-1:0] evt;
    state_e          state_q, state_d;
    logic [NIRQ-1:0] pending_q, pending_d;
    logic [NIRQ-1:0] mask_q, mask_d;
    logic [4:0]      active_q, active_d;
    logic [31:0]     d_out_q, d_out_d;
    logic [31:0]     pend_ext, mask_ext, ack_onehot;
    logic            wr, rd;

    irq_latch_sync #(
        .NIRQ        (NIRQ),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .irqs  (irqs),
        .evt   (evt)
    );

    always_comb begin
        wr         = strobe & rw;
        rd         = strobe & ~rw;
        pend_ext   = '0;
        pend_ext[NIRQ-1:0] = pending_q;
        mask_ext   = '0;
        mask_ext[NIRQ-1:0] = mask_q;
        ack_onehot = 32'd1 << active_q;

        state_d    = state_q;
        pending_d  = pending_q;
        mask_d     = mask_q;
        active_d   = active_q;
        d_out_d    = d_out_q;

        if (wr && addr == ADDR_PENDING) pending_d = pending_d & ~d_in[NIRQ-1:0];
        if (wr && addr == ADDR_MASK)    mask_d    = d_in[NIRQ-1:0];

        case (state_q)
            ST_IDLE: begin
                if (|(pend_ext & mask_ext)) begin
                    active_d = lowest_idx(pend_ext & mask_ext);
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                // Only ack leaves REQ; mask/pending changes never retract it.
                if (irq_ack) begin
                    pending_d = pending_d & ~ack_onehot[NIRQ-1:0];
                    state_d   = ST_GAP;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // New events are applied last so they win over W1C and ack clears.
        pending_d = pending_d | evt;

        if (rd) begin
            case (addr)
                ADDR_PENDING: d_out_d = pend_ext;
                ADDR_MASK:    d_out_d = mask_ext;
                ADDR_ACTIVE:  d_out_d = {27'b0, active_q};
                default:      d_out_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            mask_q    <= '0;
            active_q  <= '0;
            d_out_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            active_q  <= active_d;
            d_out_q   <= d_out_d;
        end
    end

    // Decoded straight from the state flop so reset drops it asynchronously.
    assign irq_req = (state_q == ST_REQ);
    assign irq_num = active_q;
    assign d_out   = d_out_q;

endmodule

// File: tb/tb_irq_latch.sv
module tb_irq_latch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] irqs = '0;
    logic        strobe = 1'b0;
    logic        rw = 1'b0;
    logic [1:0]  addr = '0;
    logic [31:0] d_in = '0;
    logic [31:0] d_out;
    logic        irq_req;
    logic [4:0]  irq_num;
    logic        irq_ack = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    irq_latch #(.NIRQ(32), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .irqs    (irqs),
        .strobe  (strobe),
        .rw      (rw),
        .addr    (addr),
        .d_in    (d_in),
        .d_out   (d_out),
        .irq_req (irq_req),
        .irq_num (irq_num),
        .irq_ack (irq_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; return at the following falling edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        strobe = 1'b1; rw = 1'b1; addr = a; d_in = d;
        tick();
        strobe = 1'b0; rw = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        strobe = 1'b1; rw = 1'b0; addr = a;
        tick();
        strobe = 1'b0;
        d = d_out;
    endtask

    logic [31:0] r;

    initial begin
        // reset state
        tick(2);
        reset = 1'b0;
        tick();
        chk("rst_req", 32'(irq_req), 32'd0);
        chk("rst_num", 32'(irq_num), 32'd0);
        chk("rst_dout", d_out, 32'd0);
        rd(2'd0, r); chk("rst_pend", r, 32'd0);
        rd(2'd1, r); chk("rst_mask", r, 32'd0);
        rd(2'd2, r); chk("rst_act", r, 32'd0);

        // single pulse, exact latency
        wr(2'd1, 32'h5);
        irqs = 32'h4;
        tick(3);                     // edges N, N+1, N+2
        irqs = '0;
        chk("p_pre_req", 32'(irq_req), 32'd0);
        strobe = 1'b1; rw = 1'b0; addr = 2'd0;
        tick();                      // N+3: d_out holds pre-set PENDING
        chk("p_pend_early", d_out, 32'd0);
        tick();                      // N+4
        strobe = 1'b0;
        chk("p_pend", d_out, 32'h4);
        chk("p_req", 32'(irq_req), 32'd1);
        chk("p_num", 32'(irq_num), 32'd2);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("p_gap", 32'(irq_req), 32'd0);
        tick();
        chk("p_idle", 32'(irq_req), 32'd0);
        rd(2'd0, r); chk("p_pend_clr", r, 32'd0);

        // priority, held-high lines
        wr(2'd1, 32'hFFFF_FFFF);
        irqs = 32'h88;
        tick(5);
        chk("pr_req", 32'(irq_req), 32'd1);
        chk("pr_num3", 32'(irq_num), 32'd3);
        rd(2'd2, r); chk("pr_act", r, 32'd3);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk("pr_gap", 32'(irq_req), 32'd0);
        tick(2);
        chk("pr_req2", 32'(irq_req), 32'd1);
        chk("pr_num7", 32'(irq_num), 32'd7);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        tick(4);
        chk("pr_held_req", 32'(irq_req), 32'd0);
        rd(2'd0, r); chk("pr_held_pend", r, 32'd0);
        irqs = '0;
        tick(4);

        // masked pending, late unmask, request sticky in REQ
        wr(2'd1, 32'h0);
        irqs = 32'h10;
        tick(3);
        irqs = '0;
        tick(3);
        rd(2'd0, r); chk("m_pend", r, 32'h10);
        chk("m_noreq", 32'(irq_req), 32'd0);
        wr(2'd1, 32'h10);
        chk("m_req_lat", 32'(irq_req), 32'd0);
        tick();
        chk("m_req", 32'(irq_req), 32'd1);
        chk("m_num", 32'(irq_num), 32'd4);
        wr(2'd1, 32'h0);
        chk("m_sticky_mask", 32'(irq_req), 32'd1);
        wr(2'd0, 32'h10);
        chk("m_sticky_w1c", 32'(irq_req), 32'd1);
        chk("m_sticky_num", 32'(irq_num), 32'd4);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        tick(2);
        chk("m_done", 32'(irq_req), 32'd0);
        rd(2'd0, r); chk("m_pend_clr", r, 32'd0);

        // new edge lands in the ack cycle
        wr(2'd1, 32'h2);
        irqs = 32'h2;
        tick(5);
        chk("a_req", 32'(irq_req), 32'd1);
        chk("a_num", 32'(irq_num), 32'd1);
        irqs = '0;
        tick(4);
        irqs = 32'h2;
        tick(3);                     // event registered, PENDING sets next edge
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk("a_gap", 32'(irq_req), 32'd0);
        rd(2'd0, r); chk("a_pend_kept", r, 32'h2);
        tick();
        chk("a_req2", 32'(irq_req), 32'd1);
        chk("a_num2", 32'(irq_num), 32'd1);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irqs = '0;
        tick(4);

        // W1C vs simultaneous event, register map
        wr(2'd1, 32'h0);
        irqs = 32'h1;
        tick(3);
        wr(2'd0, 32'h1);             // same edge as PENDING[0] set
        rd(2'd0, r); chk("w_evt_wins", r, 32'h1);
        wr(2'd0, 32'h1);
        rd(2'd0, r); chk("w_w1c", r, 32'h0);
        wr(2'd1, 32'hA5);
        rd(2'd1, r); chk("w_mask", r, 32'hA5);
        tick();
        chk("w_hold", d_out, 32'hA5);
        rd(2'd3, r); chk("w_rsvd", r, 32'h0);
        wr(2'd2, 32'h1F);
        wr(2'd3, 32'hFFFF);
        rd(2'd2, r); chk("w_act_ro", r, 32'h1);
        rd(2'd1, r); chk("w_rsvd_ro", r, 32'hA5);
        wr(2'd1, 32'h0);
        irqs = '0;
        tick(4);

        // reset mid-REQ
        wr(2'd1, 32'h1);
        irqs = 32'h1;
        tick(5);
        chk("r_req", 32'(irq_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("r_async", 32'(irq_req), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(6);
        chk("r_noreq", 32'(irq_req), 32'd0);
        rd(2'd0, r); chk("r_pend", r, 32'd0);
        rd(2'd1, r); chk("r_mask", r, 32'd0);
        rd(2'd2, r); chk("r_act", r, 32'd0);
        wr(2'd1, 32'h1);
        tick(5);
        chk("r_no_evt", 32'(irq_req), 32'd0);
        rd(2'd0, r); chk("r_no_pend", r, 32'd0);
        irqs = '0;
        tick(4);
        irqs = 32'h1;
        tick(5);
        chk("r_rearm_req", 32'(irq_req), 32'd1);
        chk("r_rearm_num", 32'(irq_num), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_latch.md
IRQ_LATCH -- requirements
Module: irq_latch

Interface
REQ-001 SHALL have parameter NIRQ, default 32, number of interrupt input lines (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops per irq line (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port irqs  input  NIRQ  asynchronous level interrupt lines; a rising edge is an event.
REQ-006 SHALL have port strobe  input  1  bus access this cycle.
REQ-007 SHALL have port rw  input  1  1 = write, 0 = read.
REQ-008 SHALL have port addr  input  2  register select: 0 PENDING, 1 MASK, 2 ACTIVE, 3 reserved.
REQ-009 SHALL have port d_in  input  32  write data.
REQ-010 SHALL have port d_out  output  32  registered read data.
REQ-011 SHALL have port irq_req  output  1  interrupt request to core.
REQ-012 SHALL have port irq_num  output  5  index of requested line, valid while irq_req=1.
REQ-013 SHALL have port irq_ack  input  1  core accepts current request.

Function
REQ-014 SHALL pass each irqs bit through SYNC_STAGES flops, then a one-flop edge detector; event = sync high and previous low.
REQ-015 SHALL set PENDING[i] on the cycle after the event; input high at sample edge N gives PENDING visible at edge N+SYNC_STAGES+1.
REQ-016 SHALL treat held-high lines as one event; no re-set until line goes low then high.
REQ-017 SHALL implement FSM states IDLE, REQ, GAP.
REQ-018 IDLE: if (PENDING & MASK) nonzero, capture lowest set index into ACTIVE/irq_num, go REQ; else stay.
REQ-019 REQ: irq_req=1, irq_num stable; on irq_ack clear PENDING[ACTIVE], go GAP; otherwise stay.
REQ-020 GAP: irq_req=0 for exactly one cycle, then IDLE.
REQ-021 SHALL not retract or change a request in REQ when MASK or PENDING changes; only irq_ack leaves REQ.
REQ-022 SHALL let a new event on the same bit in the ack cycle win: PENDING[i] stays 1.
REQ-023 irq_ack outside REQ SHALL be ignored.
REQ-024 Write PENDING: write-1-to-clear per bit; a simultaneous new event on that bit wins (set).
REQ-025 Write MASK: load d_in[NIRQ-1:0]; bits >= NIRQ ignored.
REQ-026 ACTIVE and reserved address SHALL be read-only; writes ignored.
REQ-027 Reads SHALL present data on d_out one cycle after strobe; d_out holds its value otherwise; unused bits read 0; ACTIVE reads {27'b0, irq_num}, reserved reads 0.
REQ-028 A write to PENDING clearing ACTIVE's bit while in REQ SHALL not abort REQ; the later ack clear is a no-op.

Reset
REQ-029 On reset: sync/edge flops 0, PENDING 0, MASK 0, ACTIVE 0, state IDLE, irq_req 0, irq_num 0, d_out 0.
REQ-030 Reset asserted mid-REQ SHALL drop irq_req immediately (asynchronously), lose all pending events.
REQ-031 A line high when reset deasserts SHALL NOT create an event (edge flop loads 0, sync must see low first) .

Structure
REQ-032 Register addresses, state encoding and NIRQ upper bound SHALL live in the shared common.vh include.
REQ-033 One sub-module, irq_sync (parameterised SYNC_STAGES-deep synchronizer plus edge detect, one instance per vector), is natural; the remainder is flat.

Verification
REQ-034 MASK=0x5, pulse irqs[2] 3 cycles -> PENDING=0x4 at edge SYNC_STAGES+1; irq_req next cycle, irq_num=2; ack -> PENDING=0, one GAP cycle.
REQ-035 MASK=0xFFFFFFFF, raise irqs[7] and irqs[3] same cycle -> irq_num=3 first; after ack and GAP, irq_num=7.
REQ-036 MASK=0, pulse irqs[4] -> PENDING=0x10, irq_req stays 0; write MASK=0x10 -> irq_req within 2 cycles, irq_num=4.
REQ-037 In REQ for line 1, new edge on irqs[1] timed so event lands in ack cycle -> PENDING[1] remains 1, second request after GAP.
REQ-038 Write PENDING=0x1 in same cycle an event sets bit 0 -> PENDING[0]=1; read addr 3 -> d_out=0.
REQ-039 Assert reset during REQ -> irq_req=0 before next clk edge; all registers 0; line held high through reset deassert -> no event.
